// File: rtl/regfile_wb_sched.sv
// Commit write-back scheduler: buffers up to two in-order commits per cycle and drains one
// register-file write per cycle. Optional forwarding lookup is enabled by WB_SCHED_FWD_EN.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module regfile_wb_sched #(
  parameter int DEPTH = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      clear_flag,
  input  logic                      cmt_a_valid,
  input  logic [4:0]                cmt_a_reg,
  input  logic [`ROB_WIDTH_BIT-1:0] cmt_a_rob,
  input  logic [31:0]               cmt_a_val,
  input  logic                      cmt_b_valid,
  input  logic [4:0]                cmt_b_reg,
  input  logic [`ROB_WIDTH_BIT-1:0] cmt_b_rob,
  input  logic [31:0]               cmt_b_val,
  output logic                      cmt_ready,
  output logic [4:0]                write_reg_id,
  output logic [`ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]               write_val,
  input  logic [4:0]                fwd_reg_id,
  output logic                      fwd_hit,
  output logic [31:0]               fwd_val,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = `ROB_WIDTH_BIT;

  logic [4:0]    ent_reg_r [DEPTH];
  logic [RW-1:0] ent_rob_r [DEPTH];
  logic [31:0]   ent_val_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          keep_a_s;
  logic          keep_b_s;
  logic          enq_s;
  logic          drain_s;
  logic [CW-1:0] kept_s;
  logic [PW-1:0] slot_b_s;

  // Admission and drain decisions, all from registered occupancy.
  always_comb begin
    keep_a_s  = cmt_a_valid && (cmt_a_reg != 5'd0);
    keep_b_s  = cmt_b_valid && (cmt_b_reg != 5'd0);
    cmt_ready = rdy_in && (count_r <= CW'(DEPTH - 2));
    enq_s     = cmt_ready;
    drain_s   = rdy_in && !clear_flag && (count_r != {CW{1'b0}});
    if (enq_s) begin
      kept_s = CW'(keep_a_s) + CW'(keep_b_s);
    end else begin
      kept_s = {CW{1'b0}};
    end
    // B lands right behind A, or at tail when A was dropped or absent.
    if (keep_a_s) begin
      slot_b_s = tail_r + PW'(1'b1);
    end else begin
      slot_b_s = tail_r;
    end
  end

  // Write port shows the head entry only in cycles where it is actually written.
  always_comb begin
    if (drain_s) begin
      write_reg_id = ent_reg_r[head_r];
      write_ROB_id = ent_rob_r[head_r];
      write_val    = ent_val_r[head_r];
    end else begin
      write_reg_id = 5'd0;
      write_ROB_id = {RW{1'b0}};
      write_val    = 32'd0;
    end
  end

  // FIFO storage, pointers and entry count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_r[i] <= 5'd0;
        ent_rob_r[i] <= {RW{1'b0}};
        ent_val_r[i] <= 32'd0;
      end
    end else begin
      if (enq_s && keep_a_s) begin
        ent_reg_r[tail_r] <= cmt_a_reg;
        ent_rob_r[tail_r] <= cmt_a_rob;
        ent_val_r[tail_r] <= cmt_a_val;
      end
      if (enq_s && keep_b_s) begin
        ent_reg_r[slot_b_s] <= cmt_b_reg;
        ent_rob_r[slot_b_s] <= cmt_b_rob;
        ent_val_r[slot_b_s] <= cmt_b_val;
      end
      tail_r <= tail_r + kept_s[PW-1:0];
      if (drain_s) begin
        head_r <= head_r + PW'(1'b1);
      end
      count_r <= count_r + kept_s - CW'(drain_s);
    end
  end

  assign occupancy = count_r;

`ifdef WB_SCHED_FWD_EN
  logic [PW-1:0] fwd_idx_s;

  // Walk from oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_val   = 32'd0;
    fwd_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_r + PW'(i);
      if ((CW'(i) < count_r) && (fwd_reg_id != 5'd0) && (ent_reg_r[fwd_idx_s] == fwd_reg_id)) begin
        fwd_hit = 1'b1;
        fwd_val = ent_val_r[fwd_idx_s];
      end else begin
        fwd_hit = fwd_hit;
        fwd_val = fwd_val;
      end
    end
  end
`else
  logic unused_fwd_s;

  assign unused_fwd_s = ^fwd_reg_id;
  assign fwd_hit      = 1'b0;
  assign fwd_val      = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (DEPTH = 4).
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module tb_regfile_wb_sched;

  localparam int DEPTH = 4;
  localparam int RW = `ROB_WIDTH_BIT;
`ifdef WB_SCHED_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_in;
  logic          rst_n_in;
  logic          rdy_in;
  logic          clear_flag;
  logic          cmt_a_valid, cmt_b_valid;
  logic [4:0]    cmt_a_reg, cmt_b_reg;
  logic [RW-1:0] cmt_a_rob, cmt_b_rob;
  logic [31:0]   cmt_a_val, cmt_b_val;
  logic          cmt_ready;
  logic [4:0]    write_reg_id;
  logic [RW-1:0] write_ROB_id;
  logic [31:0]   write_val;
  logic [4:0]    fwd_reg_id;
  logic          fwd_hit;
  logic [31:0]   fwd_val;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;

  regfile_wb_sched #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .cmt_a_valid(cmt_a_valid), .cmt_a_reg(cmt_a_reg), .cmt_a_rob(cmt_a_rob), .cmt_a_val(cmt_a_val),
    .cmt_b_valid(cmt_b_valid), .cmt_b_reg(cmt_b_reg), .cmt_b_rob(cmt_b_rob), .cmt_b_val(cmt_b_val),
    .cmt_ready(cmt_ready), .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id),
    .write_val(write_val), .fwd_reg_id(fwd_reg_id), .fwd_hit(fwd_hit), .fwd_val(fwd_val),
    .occupancy(occupancy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic av, input logic [4:0] ar, input logic [RW-1:0] ao, input logic [31:0] aw,
                       input logic bv, input logic [4:0] br, input logic [RW-1:0] bo, input logic [31:0] bw);
    cmt_a_valid = av; cmt_a_reg = ar; cmt_a_rob = ao; cmt_a_val = aw;
    cmt_b_valid = bv; cmt_b_reg = br; cmt_b_rob = bo; cmt_b_val = bw;
  endtask

  task automatic idle();
    offer(1'b0, 5'd0, '0, 32'd0, 1'b0, 5'd0, '0, 32'd0);
  endtask

  initial begin
    int rdy_e [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
    int occ_e [8] = '{0, 2, 3, 2, 3, 2, 1, 0};
    int wr_e  [8] = '{0, 1, 2, 1, 2, 1, 2, 0};

    rst_n_in = 1'b0; rdy_in = 1'b0; clear_flag = 1'b0; fwd_reg_id = 5'd0;
    idle();
    #2;
    check_eq("rst_ready", 64'(cmt_ready), 64'd0);
    check_eq("rst_wreg", 64'(write_reg_id), 64'd0);
    check_eq("rst_wval", 64'(write_val), 64'd0);
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_fwd", 64'(fwd_hit), 64'd0);
    #10 rst_n_in = 1'b1;
    rdy_in = 1'b1;
    tick();

    // single commit, one-cycle latency
    offer(1'b1, 5'd5, RW'(3), 32'hDEADBEEF, 1'b0, 5'd0, '0, 32'd0);
    #1;
    check_eq("single_ready", 64'(cmt_ready), 64'd1);
    check_eq("single_empty", 64'(write_reg_id), 64'd0);
    tick();
    idle();
    check_eq("single_reg", 64'(write_reg_id), 64'd5);
    check_eq("single_rob", 64'(write_ROB_id), 64'd3);
    check_eq("single_val", 64'(write_val), 64'hDEADBEEF);
    check_eq("single_occ1", 64'(occupancy), 64'd1);
    tick();
    check_eq("single_done", 64'(write_reg_id), 64'd0);
    check_eq("single_occ0", 64'(occupancy), 64'd0);

    // dual commits every cycle: backpressure, strict order, pointer wrap
    for (int c = 0; c < 8; c++) begin
      if (c < 4) offer(1'b1, 5'd1, RW'(1), 32'h11, 1'b1, 5'd2, RW'(2), 32'h22);
      else idle();
      #1;
      check_eq($sformatf("dual_ready%0d", c), 64'(cmt_ready), 64'(rdy_e[c]));
      check_eq($sformatf("dual_occ%0d", c), 64'(occupancy), 64'(occ_e[c]));
      check_eq($sformatf("dual_reg%0d", c), 64'(write_reg_id), 64'(wr_e[c]));
      check_eq($sformatf("dual_rob%0d", c), 64'(write_ROB_id), 64'(wr_e[c]));
      check_eq($sformatf("dual_val%0d", c), 64'(write_val),
               (wr_e[c] == 1) ? 64'h11 : ((wr_e[c] == 2) ? 64'h22 : 64'h0));
      tick();
    end

    // clear_flag stalls the port but keeps entries
    offer(1'b1, 5'd3, RW'(5), 32'h33, 1'b1, 5'd4, RW'(6), 32'h44);
    tick();
    idle();
    clear_flag = 1'b1;
    #1;
    check_eq("clr_port", 64'(write_reg_id), 64'd0);
    check_eq("clr_occ_a", 64'(occupancy), 64'd2);
    tick();
    clear_flag = 1'b0;
    #1;
    check_eq("clr_occ_b", 64'(occupancy), 64'd2);
    check_eq("clr_reg3", 64'(write_reg_id), 64'd3);
    check_eq("clr_val3", 64'(write_val), 64'h33);
    tick();
    check_eq("clr_occ_c", 64'(occupancy), 64'd1);
    check_eq("clr_reg4", 64'(write_reg_id), 64'd4);
    check_eq("clr_rob4", 64'(write_ROB_id), 64'd6);
    tick();
    check_eq("clr_occ_d", 64'(occupancy), 64'd0);
    check_eq("clr_empty", 64'(write_reg_id), 64'd0);

    // x0 in slot A is dropped
    offer(1'b1, 5'd0, RW'(7), 32'h99, 1'b1, 5'd7, RW'(4), 32'h77);
    tick();
    idle();
    check_eq("x0_occ", 64'(occupancy), 64'd1);
    check_eq("x0_reg", 64'(write_reg_id), 64'd7);
    check_eq("x0_rob", 64'(write_ROB_id), 64'd4);
    check_eq("x0_val", 64'(write_val), 64'h77);
    tick();
    check_eq("x0_occ0", 64'(occupancy), 64'd0);

    // rdy_in low: no enqueue, no drain, port zero
    rdy_in = 1'b0;
    offer(1'b1, 5'd8, RW'(1), 32'h88, 1'b0, 5'd0, '0, 32'd0);
    #1;
    check_eq("rdy_ready", 64'(cmt_ready), 64'd0);
    tick();
    check_eq("rdy_noenq", 64'(occupancy), 64'd0);
    rdy_in = 1'b1;
    tick();
    idle();
    rdy_in = 1'b0;
    #1;
    check_eq("rdy_hold_port", 64'(write_reg_id), 64'd0);
    tick();
    check_eq("rdy_hold_occ", 64'(occupancy), 64'd1);
    rdy_in = 1'b1;
    #1;
    check_eq("rdy_resume", 64'(write_reg_id), 64'd8);
    tick();
    check_eq("rdy_occ0", 64'(occupancy), 64'd0);

    // fill to DEPTH under clear_flag, then drain in order
    clear_flag = 1'b1;
    offer(1'b1, 5'd20, RW'(0), 32'h20, 1'b1, 5'd21, RW'(1), 32'h21);
    tick();
    offer(1'b1, 5'd22, RW'(2), 32'h22, 1'b1, 5'd23, RW'(3), 32'h23);
    tick();
    offer(1'b1, 5'd24, RW'(4), 32'h24, 1'b1, 5'd25, RW'(5), 32'h25);
    #1;
    check_eq("full_ready", 64'(cmt_ready), 64'd0);
    check_eq("full_occ", 64'(occupancy), 64'd4);
    tick();
    idle();
    check_eq("full_ignored", 64'(occupancy), 64'd4);
    clear_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("full_drain%0d", k), 64'(write_reg_id), 64'(20 + k));
      check_eq($sformatf("full_dval%0d", k), 64'(write_val), 64'(32 + k));
      tick();
    end
    check_eq("full_occ0", 64'(occupancy), 64'd0);

    // forwarding: youngest match wins; x0 never hits
    clear_flag = 1'b1;
    offer(1'b1, 5'd9, RW'(1), 32'h1, 1'b1, 5'd9, RW'(2), 32'h2);
    tick();
    idle();
    fwd_reg_id = 5'd9;
    #1;
    check_eq("fwd_hit9", 64'(fwd_hit), 64'(FWD));
    check_eq("fwd_val9", 64'(fwd_val), FWD ? 64'h2 : 64'h0);
    fwd_reg_id = 5'd0;
    #1;
    check_eq("fwd_hit0", 64'(fwd_hit), 64'd0);
    clear_flag = 1'b0;
    tick();
    tick();
    check_eq("fwd_occ0", 64'(occupancy), 64'd0);

    // reset mid-operation with 3 entries queued
    clear_flag = 1'b1;
    offer(1'b1, 5'd10, RW'(1), 32'hA, 1'b1, 5'd11, RW'(2), 32'hB);
    tick();
    offer(1'b1, 5'd12, RW'(3), 32'hC, 1'b0, 5'd0, '0, 32'd0);
    tick();
    idle();
    clear_flag = 1'b0;
    #1;
    check_eq("mrst_occ3", 64'(occupancy), 64'd3);
    check_eq("mrst_head", 64'(write_reg_id), 64'd10);
    rst_n_in = 1'b0;
    #1;
    check_eq("mrst_reg", 64'(write_reg_id), 64'd0);
    check_eq("mrst_val", 64'(write_val), 64'd0);
    check_eq("mrst_occ", 64'(occupancy), 64'd0);
    rst_n_in = 1'b1;
    offer(1'b1, 5'd13, RW'(2), 32'h1313, 1'b0, 5'd0, '0, 32'd0);
    tick();
    idle();
    check_eq("mrst_new_reg", 64'(write_reg_id), 64'd13);
    check_eq("mrst_new_val", 64'(write_val), 64'h1313);
    tick();
    check_eq("mrst_new_occ", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Commit write-back scheduler between the ROB commit stage and the register file's single write port. Accepts up to two in-order commits per cycle (slot A older, slot B younger) and buffers them in a small FIFO. Drains exactly one write per cycle onto the register-file write port, and holds that port idle in any cycle where `clear_flag` is high, because the register file ignores writes in that cycle. Optionally exposes a forwarding lookup so issue can read committed-but-not-yet-written values.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- ROB id width is fixed to `` `ROB_WIDTH_BIT `` from const.v; not a parameter.

Ports:
- `clk_in`  in  1  system clock
- `rst_n_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global ready; pause when low
- `clear_flag`  in  1  misprediction flush pulse
- `cmt_a_valid`, `cmt_b_valid`  in  1 each  commit slot valid (A older than B)
- `cmt_a_reg`, `cmt_b_reg`  in  5 each  destination register
- `cmt_a_rob`, `cmt_b_rob`  in  `` `ROB_WIDTH_BIT `` each  ROB id of the committing entry
- `cmt_a_val`, `cmt_b_val`  in  32 each  result value
- `cmt_ready`  out  1  both slots may be offered this cycle
- `write_reg_id`  out  5  to register file; 0 = no write
- `write_ROB_id`  out  `` `ROB_WIDTH_BIT ``  to register file
- `write_val`  out  32  to register file
- `fwd_reg_id`  in  5  lookup register (only with `WB_SCHED_FWD_EN`)
- `fwd_hit`  out  1  pending write to `fwd_reg_id` exists
- `fwd_val`  out  32  value of the youngest pending write
- `occupancy`  out  log2(DEPTH)+1  current entry count

## Operation
- FIFO entry holds {reg[4:0], rob id, val[31:0]}. It is a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap naturally, plus a `count` register.
- Enqueue occurs at a posedge when `rdy_in` and `cmt_ready` are high.
  - A valid slot whose reg is 0 is dropped and consumes no entry.
  - If A and B are both kept, A is written at tail and B at tail+1.
  - B valid with A invalid is legal; B then enqueues alone.
  - Offers while `cmt_ready` is low are a protocol violation. Ignore them and do not corrupt state.
- `cmt_ready` = `rdy_in` && (`count` ≤ DEPTH−2). It is computed from registered `count` only, ignoring a same-cycle pop.
- Dequeue behaviour:
  - `drain` = `rdy_in` && !`clear_flag` && (`count` ≠ 0).
  - When `drain` is high, the write port carries the head entry; otherwise it carries all zeros.
  - Head advances at the posedge where `drain` is high.
- Outputs are combinational from registered head; no combinational path from `cmt_*` to `write_*`.
- `clear_flag` never discards entries, since committed writes are architectural. It only stalls draining for that cycle. Enqueue in the same cycle still proceeds.
- Simultaneous enqueue of up to 2 and dequeue of 1: `count` <= `count` + kept − `drain`.
- Forwarding (macro on):
  - `fwd_hit` = (`fwd_reg_id` ≠ 0) && any valid entry has reg == `fwd_reg_id`.
  - `fwd_val` is taken from the youngest match, i.e. closest to tail.
  - The head entry counts even in the cycle it is being written.
  - Purely combinational on registered state.
- `rdy_in` low: no enqueue, no dequeue, write port zero, state held.

## Timing
- Reset (async assert, sync release) values:
  - count, head and tail are 0.
  - `write_*` = 0, `cmt_ready` = 0 while `rdy_in` is low, `fwd_hit` = 0, `fwd_val` = 0, `occupancy` = 0.
- Reset asserted mid-operation empties the FIFO immediately; pending writes are lost.
- Latency: an entry enqueued at edge N appears on the write port in cycle N+1 (if it is the head and `clear_flag` is low) and is written to the register file at edge N+1.
- Throughput: one write per cycle sustained. A stream of dual commits saturates and backpressures via `cmt_ready`.
- Full (`count` = DEPTH): no further enqueue; drain continues.
- Empty: write port zero.
- Wrap-around of tail+1 past DEPTH−1 is handled modulo DEPTH.

## Configuration
- `WB_SCHED_FWD_EN` defined: forwarding compare logic and `fwd_*` behaviour as above.
- Undefined: the `fwd_reg_id` port is still present but ignored; `fwd_hit` and `fwd_val` are tied to 0; no compare logic is synthesized.

## Test plan
- Single commit A={x5, rob 3, 0xDEADBEEF} into an empty FIFO → next cycle `write_reg_id`=5, `write_ROB_id`=3, `write_val`=0xDEADBEEF; the cycle after, the port is 0 and `occupancy`=0.
- Dual commits A={x1,rob1,0x11}, B={x2,rob2,0x22} every cycle for 4 cycles, DEPTH=4 → `cmt_ready` drops when `count`≥3; writes emerge x1,x2,x1,x2… in strict order; no entry is lost.
- `clear_flag` high for one cycle with 2 entries queued → write port is 0 that cycle, both entries drain afterward, `occupancy` goes 2→2→1→0.
- A={x0,…}, B={x7,rob4,0x77} → only the x7 entry is enqueued and written; `occupancy` peaks at 1.
- With `WB_SCHED_FWD_EN`: queue x9=0x1 then x9=0x2 and set `fwd_reg_id`=9 → `fwd_hit`=1 and `fwd_val`=0x2; with `fwd_reg_id`=0 → `fwd_hit`=0.
- Assert `rst_n_in` low with 3 entries queued → all outputs are 0 immediately; after release, a new commit writes within 1 cycle.
